// File: rtl/wb_stage_pkg.sv
// Shared definitions for the writeback stage: MEM latch layout, canary value,
// FSM state encoding and WB-to-DE/AGEX bus widths.
package wb_stage_pkg;

  localparam int unsigned WB_DBITS        = 32;
  localparam int unsigned WB_INSTBITS     = 32;
  localparam int unsigned WB_REGNOBITS    = 5;
  localparam int unsigned WB_CANARY_W     = 4;
  localparam logic [3:0]  WB_CANARY_VAL   = 4'hF;
  localparam int unsigned WB_DRAIN_CYCLES = 3;

  localparam logic [1:0] ST_RUN    = 2'd0;
  localparam logic [1:0] ST_DRAIN  = 2'd1;
  localparam logic [1:0] ST_HALTED = 2'd2;

  // {valid, inst, pc, inst_count, result, rd, wr_reg, is_halt, canary}, MSB first
  function automatic int unsigned mem_latch_width(int unsigned dbits, int unsigned instbits,
                                                  int unsigned regnobits, int unsigned canary_w);
    return 1 + instbits + 2 * dbits + dbits + regnobits + 2 + canary_w;
  endfunction

  // {commit_wr, rd, result}
  function automatic int unsigned wb_bus_width(int unsigned dbits, int unsigned regnobits);
    return 1 + regnobits + dbits;
  endfunction

endpackage

// File: rtl/wb_stage_if.sv
// Bundle of the MEM latch, DE read ports and WB status/bypass outputs.
interface wb_stage_if
  import wb_stage_pkg::*;
#(
  parameter int unsigned DBITS     = WB_DBITS,
  parameter int unsigned INSTBITS  = WB_INSTBITS,
  parameter int unsigned REGNOBITS = WB_REGNOBITS,
  parameter int unsigned CANARY_W  = WB_CANARY_W
) ();

  localparam int unsigned MEM_LATCH_W = mem_latch_width(DBITS, INSTBITS, REGNOBITS, CANARY_W);
  localparam int unsigned BUS_W       = wb_bus_width(DBITS, REGNOBITS);

  logic [MEM_LATCH_W-1:0] mem_latch_in;
  logic [REGNOBITS-1:0]   rs1_idx;
  logic [REGNOBITS-1:0]   rs2_idx;
  logic [DBITS-1:0]       rs1_val;
  logic [DBITS-1:0]       rs2_val;
  logic [BUS_W-1:0]       from_WB_to_DE;
  logic [BUS_W-1:0]       from_WB_to_AGEX;
  logic [DBITS-1:0]       retired_count;
  logic                   halted;
  logic                   canary_err;
  logic [DBITS-1:0]       last_pc;

  modport master (
    output mem_latch_in, rs1_idx, rs2_idx,
    input  rs1_val, rs2_val, from_WB_to_DE, from_WB_to_AGEX,
    input  retired_count, halted, canary_err, last_pc
  );

  modport slave (
    input  mem_latch_in, rs1_idx, rs2_idx,
    output rs1_val, rs2_val, from_WB_to_DE, from_WB_to_AGEX,
    output retired_count, halted, canary_err, last_pc
  );

endinterface

// File: rtl/wb_stage_regfile.sv
// Architectural register file: one write port, two combinational read ports
// with write-through, register 0 hardwired to zero.
module wb_regfile #(
  parameter int unsigned DBITS     = 32,
  parameter int unsigned REGNOBITS = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 we,
  input  logic [REGNOBITS-1:0] waddr,
  input  logic [DBITS-1:0]     wdata,
  input  logic [REGNOBITS-1:0] raddr1,
  input  logic [REGNOBITS-1:0] raddr2,
  output logic [DBITS-1:0]     rdata1,
  output logic [DBITS-1:0]     rdata2
);

  localparam int unsigned NREGS = 1 << REGNOBITS;

  logic [DBITS-1:0] regs [NREGS];
  logic             wr_en;

  assign wr_en = we && (waddr != '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_en) begin
      regs[waddr] <= wdata;
    end
  end

  // Same-cycle write wins so readers see the committing value immediately.
  always_comb begin
    rdata1 = '0;
    if (raddr1 != '0) begin
      rdata1 = (wr_en && (waddr == raddr1)) ? wdata : regs[raddr1];
    end
  end

  always_comb begin
    rdata2 = '0;
    if (raddr2 != '0) begin
      rdata2 = (wr_en && (waddr == raddr2)) ? wdata : regs[raddr2];
    end
  end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: commits the MEM latch into the register file, exposes
// bypass/read ports, counts retirements and runs the halt/canary FSM.
module wb_stage
  import wb_stage_pkg::*;
#(
  parameter int unsigned         DBITS        = WB_DBITS,
  parameter int unsigned         INSTBITS     = WB_INSTBITS,
  parameter int unsigned         REGNOBITS    = WB_REGNOBITS,
  parameter int unsigned         CANARY_W     = WB_CANARY_W,
  parameter logic [CANARY_W-1:0] CANARY_VAL   = CANARY_W'(WB_CANARY_VAL),
  parameter int unsigned         DRAIN_CYCLES = WB_DRAIN_CYCLES
) (
  input logic       clk,
  input logic       reset,
  wb_stage_if.slave bus
);

  localparam int unsigned MEM_LATCH_W = mem_latch_width(DBITS, INSTBITS, REGNOBITS, CANARY_W);
  localparam int unsigned CNT_W       = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  localparam int unsigned CAN_LSB   = 0;
  localparam int unsigned HALT_BIT  = CANARY_W;
  localparam int unsigned WR_BIT    = CANARY_W + 1;
  localparam int unsigned RD_LSB    = CANARY_W + 2;
  localparam int unsigned RES_LSB   = RD_LSB + REGNOBITS;
  localparam int unsigned ICNT_LSB  = RES_LSB + DBITS;
  localparam int unsigned PC_LSB    = ICNT_LSB + DBITS;
  localparam int unsigned INST_LSB  = PC_LSB + DBITS;
  localparam int unsigned VALID_BIT = MEM_LATCH_W - 1;

  logic                 lat_valid;
  logic [INSTBITS-1:0]  lat_inst;
  logic [DBITS-1:0]     lat_pc;
  logic [DBITS-1:0]     lat_inst_count;
  logic [DBITS-1:0]     lat_result;
  logic [REGNOBITS-1:0] lat_rd;
  logic                 lat_wr_reg;
  logic                 lat_is_halt;
  logic [CANARY_W-1:0]  lat_canary;
  logic                 unused_latch_fields;

  assign lat_valid      = bus.mem_latch_in[VALID_BIT];
  assign lat_inst       = bus.mem_latch_in[INST_LSB +: INSTBITS];
  assign lat_pc         = bus.mem_latch_in[PC_LSB +: DBITS];
  assign lat_inst_count = bus.mem_latch_in[ICNT_LSB +: DBITS];
  assign lat_result     = bus.mem_latch_in[RES_LSB +: DBITS];
  assign lat_rd         = bus.mem_latch_in[RD_LSB +: REGNOBITS];
  assign lat_wr_reg     = bus.mem_latch_in[WR_BIT];
  assign lat_is_halt    = bus.mem_latch_in[HALT_BIT];
  assign lat_canary     = bus.mem_latch_in[CAN_LSB +: CANARY_W];

  assign unused_latch_fields = ^{lat_inst, lat_inst_count};

  logic [1:0]       state;
  logic [CNT_W-1:0] drain_cnt;
  logic [DBITS-1:0] retired_count;
  logic [DBITS-1:0] last_pc;
  logic             canary_err;

  logic in_run;
  logic retire;
  logic canary_bad;
  logic commit_wr;

  assign in_run     = (state == ST_RUN);
  assign retire     = lat_valid && in_run && (lat_canary == CANARY_VAL);
  assign canary_bad = lat_valid && in_run && (lat_canary != CANARY_VAL);
  // The halt instruction retires but never writes, so it must not advertise a write either.
  assign commit_wr  = retire && lat_wr_reg && !lat_is_halt && (lat_rd != '0);

  wb_regfile #(
    .DBITS     (DBITS),
    .REGNOBITS (REGNOBITS)
  ) u_regfile (
    .clk    (clk),
    .reset  (reset),
    .we     (commit_wr),
    .waddr  (lat_rd),
    .wdata  (lat_result),
    .raddr1 (bus.rs1_idx),
    .raddr2 (bus.rs2_idx),
    .rdata1 (bus.rs1_val),
    .rdata2 (bus.rs2_val)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= ST_RUN;
      drain_cnt     <= '0;
      retired_count <= '0;
      last_pc       <= '0;
      canary_err    <= 1'b0;
    end else begin
      case (state)
        ST_RUN: begin
          if (canary_bad) begin
            canary_err <= 1'b1;
            state      <= ST_HALTED;
          end else if (retire) begin
            retired_count <= retired_count + DBITS'(1);
            last_pc       <= lat_pc;
            if (lat_is_halt) begin
              state     <= ST_DRAIN;
              drain_cnt <= '0;
            end
          end
        end
        ST_DRAIN: begin
          if (drain_cnt == CNT_W'(DRAIN_CYCLES - 1)) begin
            state <= ST_HALTED;
          end else begin
            drain_cnt <= drain_cnt + CNT_W'(1);
          end
        end
        ST_HALTED: state <= ST_HALTED;
        default:   state <= ST_HALTED;
      endcase
    end
  end

  assign bus.from_WB_to_DE   = {commit_wr, lat_rd, lat_result};
  assign bus.from_WB_to_AGEX = {commit_wr, lat_rd, lat_result};
  assign bus.retired_count   = retired_count;
  assign bus.last_pc         = last_pc;
  assign bus.canary_err      = canary_err;
  assign bus.halted          = (state == ST_HALTED);

endmodule

// File: tb/tb_wb_stage.sv
// Directed self-checking bench for wb_stage; a narrow-DBITS second instance
// exercises retired_count wrap-around.
module tb_wb_stage;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  wb_stage_if #(.DBITS(32), .INSTBITS(32), .REGNOBITS(5), .CANARY_W(4)) bus ();
  wb_stage_if #(.DBITS(8),  .INSTBITS(32), .REGNOBITS(5), .CANARY_W(4)) sbus ();

  wb_stage #(
    .DBITS(32), .INSTBITS(32), .REGNOBITS(5), .CANARY_W(4),
    .CANARY_VAL(4'hF), .DRAIN_CYCLES(3)
  ) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  wb_stage #(
    .DBITS(8), .INSTBITS(32), .REGNOBITS(5), .CANARY_W(4),
    .CANARY_VAL(4'hF), .DRAIN_CYCLES(3)
  ) u_small (
    .clk   (clk),
    .reset (reset),
    .bus   (sbus)
  );

  function automatic logic [139:0] lat(logic v, logic [31:0] pc, logic [31:0] res,
                                       logic [4:0] rd, logic wr, logic halt, logic [3:0] can);
    return {v, 32'h0000_0013, pc, 32'h0, res, rd, wr, halt, can};
  endfunction

  function automatic logic [67:0] slat(logic v, logic [7:0] pc);
    return {v, 32'h0000_0013, pc, 8'h00, 8'h00, 5'd0, 1'b0, 1'b0, 4'hF};
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Pulse async reset in the middle of the high phase, away from any edge.
  task automatic pulse_reset();
    #2 reset = 1'b1;
    #1;
    check("rst_retired", 64'(bus.retired_count), 64'h0);
    check("rst_halted", 64'(bus.halted), 64'h0);
    check("rst_last_pc", 64'(bus.last_pc), 64'h0);
    check("rst_canary_err", 64'(bus.canary_err), 64'h0);
    #1 reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.mem_latch_in  = '0;
    bus.rs1_idx       = '0;
    bus.rs2_idx       = '0;
    sbus.mem_latch_in = '0;
    sbus.rs1_idx      = '0;
    sbus.rs2_idx      = '0;

    step();
    step();
    bus.rs1_idx = 5'd5;
    #1;
    check("reset_retired", 64'(bus.retired_count), 64'h0);
    check("reset_halted", 64'(bus.halted), 64'h0);
    check("reset_canary", 64'(bus.canary_err), 64'h0);
    check("reset_last_pc", 64'(bus.last_pc), 64'h0);
    check("reset_rs1", 64'(bus.rs1_val), 64'h0);
    reset = 1'b0;
    step();

    // Commit rd5 with write-through.
    bus.mem_latch_in = lat(1'b1, 32'h10, 32'hDEAD_BEEF, 5'd5, 1'b1, 1'b0, 4'hF);
    bus.rs1_idx = 5'd5;
    bus.rs2_idx = 5'd6;
    #1;
    check("bypass_rs1", 64'(bus.rs1_val), 64'hDEAD_BEEF);
    check("bypass_rs2_other", 64'(bus.rs2_val), 64'h0);
    check("to_de_bus", 64'(bus.from_WB_to_DE), {26'h0, 1'b1, 5'd5, 32'hDEAD_BEEF});
    check("to_agex_bus", 64'(bus.from_WB_to_AGEX), {26'h0, 1'b1, 5'd5, 32'hDEAD_BEEF});
    step();
    bus.mem_latch_in = '0;
    #1;
    check("commit_count", 64'(bus.retired_count), 64'd1);
    check("commit_last_pc", 64'(bus.last_pc), 64'h10);
    check("commit_persist", 64'(bus.rs1_val), 64'hDEAD_BEEF);
    step();
    check("idle_no_count", 64'(bus.retired_count), 64'd1);

    // Register 0 is never written but the instruction still retires.
    bus.mem_latch_in = lat(1'b1, 32'h14, 32'h1234, 5'd0, 1'b1, 1'b0, 4'hF);
    bus.rs1_idx = 5'd0;
    #1;
    check("r0_bypass", 64'(bus.rs1_val), 64'h0);
    check("r0_commit_wr", 64'(bus.from_WB_to_DE[37]), 64'h0);
    step();
    check("r0_count", 64'(bus.retired_count), 64'd2);
    check("r0_read", 64'(bus.rs1_val), 64'h0);

    // rs2 write-through, rs1 reads the array.
    bus.mem_latch_in = lat(1'b1, 32'h18, 32'h55AA, 5'd6, 1'b1, 1'b0, 4'hF);
    bus.rs1_idx = 5'd5;
    bus.rs2_idx = 5'd6;
    #1;
    check("rs2_bypass", 64'(bus.rs2_val), 64'h55AA);
    check("rs1_array", 64'(bus.rs1_val), 64'hDEAD_BEEF);
    step();

    // Retire without wr_reg leaves rd untouched.
    bus.mem_latch_in = lat(1'b1, 32'h1C, 32'h0, 5'd5, 1'b0, 1'b0, 4'hF);
    #1;
    check("nowr_commit_wr", 64'(bus.from_WB_to_DE[37]), 64'h0);
    step();
    check("nowr_reg", 64'(bus.rs1_val), 64'hDEAD_BEEF);
    check("nowr_count", 64'(bus.retired_count), 64'd4);

    bus.mem_latch_in = lat(1'b1, 32'h20, 32'h333, 5'd3, 1'b1, 1'b0, 4'hF);
    step();

    // Halt with wr_reg=1, rd=3.
    bus.mem_latch_in = lat(1'b1, 32'h40, 32'h777, 5'd3, 1'b1, 1'b1, 4'hF);
    bus.rs1_idx = 5'd3;
    bus.rs2_idx = 5'd7;
    step();
    bus.mem_latch_in = lat(1'b1, 32'h44, 32'h99, 5'd7, 1'b1, 1'b0, 4'hF);
    #1;
    check("halt_count", 64'(bus.retired_count), 64'd6);
    check("halt_last_pc", 64'(bus.last_pc), 64'h40);
    check("halt_reg3", 64'(bus.rs1_val), 64'h333);
    check("drain_no_bypass", 64'(bus.from_WB_to_DE[37]), 64'h0);
    check("drain_halted0", 64'(bus.halted), 64'h0);
    step();
    check("drain_halted1", 64'(bus.halted), 64'h0);
    step();
    check("drain_halted2", 64'(bus.halted), 64'h0);
    step();
    check("halted_rise", 64'(bus.halted), 64'h1);
    check("drain_no_count", 64'(bus.retired_count), 64'd6);
    check("drain_no_write", 64'(bus.rs2_val), 64'h0);
    step();
    step();
    check("halted_stays", 64'(bus.halted), 64'h1);
    check("halted_no_count", 64'(bus.retired_count), 64'd6);
    check("halted_last_pc", 64'(bus.last_pc), 64'h40);

    // Reset mid-HALTED.
    pulse_reset();
    bus.mem_latch_in = '0;
    step();

    // Reset mid-DRAIN, then a normal commit.
    bus.mem_latch_in = lat(1'b1, 32'h60, 32'h0, 5'd0, 1'b0, 1'b1, 4'hF);
    step();
    bus.mem_latch_in = '0;
    step();
    pulse_reset();
    bus.rs1_idx = 5'd5;
    #1;
    check("reset_clears_reg", 64'(bus.rs1_val), 64'h0);
    bus.mem_latch_in = lat(1'b1, 32'h64, 32'hCAFE, 5'd5, 1'b1, 1'b0, 4'hF);
    step();
    bus.mem_latch_in = '0;
    #1;
    check("post_reset_count", 64'(bus.retired_count), 64'd1);
    check("post_reset_reg", 64'(bus.rs1_val), 64'hCAFE);
    check("post_reset_halted", 64'(bus.halted), 64'h0);

    // Bad canary on a halt: error wins, nothing retires.
    bus.mem_latch_in = lat(1'b1, 32'h80, 32'hBAD, 5'd5, 1'b1, 1'b1, 4'h0);
    #1;
    check("canary_no_commit_wr", 64'(bus.from_WB_to_DE[37]), 64'h0);
    check("canary_no_bypass", 64'(bus.rs1_val), 64'hCAFE);
    step();
    bus.mem_latch_in = lat(1'b1, 32'h84, 32'h1, 5'd5, 1'b1, 1'b0, 4'hF);
    #1;
    check("canary_err_set", 64'(bus.canary_err), 64'h1);
    check("canary_halted", 64'(bus.halted), 64'h1);
    check("canary_no_count", 64'(bus.retired_count), 64'd1);
    check("canary_last_pc", 64'(bus.last_pc), 64'h64);
    step();
    check("canary_sticky", 64'(bus.canary_err), 64'h1);
    check("canary_reg_kept", 64'(bus.rs1_val), 64'hCAFE);
    bus.mem_latch_in = '0;
    #2 reset = 1'b1;
    #1;
    check("canary_cleared", 64'(bus.canary_err), 64'h0);
    #1 reset = 1'b0;
    step();

    // Wrap: 8-bit retired_count after 256 retires returns to 0.
    sbus.mem_latch_in = slat(1'b1, 8'h2A);
    for (int i = 0; i < 255; i++) begin
      step();
    end
    check("wrap_ff", 64'(sbus.retired_count), 64'hFF);
    step();
    sbus.mem_latch_in = '0;
    #1;
    check("wrap_zero", 64'(sbus.retired_count), 64'h0);
    check("wrap_last_pc", 64'(sbus.last_pc), 64'h2A);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
Writeback stage of the five-stage pipeline (FE, DE, AGEX, MEM, WB). It consumes the MEM pipeline latch and owns the architectural register file. It commits results and exposes combinational read and bypass ports to DE/AGEX, and counts retired instructions. A small retire/halt FSM stops the core and raises a sticky error on a corrupted latch canary.

Parameters:
DBITS, 32, data/PC width
INSTBITS, 32, instruction width
REGNOBITS, 5, register index width (2^REGNOBITS registers)
CANARY_W, 4, bus canary width
CANARY_VAL, 4'hF, expected canary value
DRAIN_CYCLES, 3, cycles between halt retire and HALTED
MEM_LATCH_W, 1+INSTBITS+2*DBITS+DBITS+REGNOBITS+2+CANARY_W, packed MEM latch width

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high
mem_latch_in  in  MEM_LATCH_W  packed {valid, inst, pc, inst_count, result, rd, wr_reg, is_halt, canary}, MSB first
rs1_idx  in  REGNOBITS  DE read port 1 index
rs2_idx  in  REGNOBITS  DE read port 2 index
rs1_val  out  DBITS  read port 1 data
rs2_val  out  DBITS  read port 2 data
from_WB_to_DE  out  1+REGNOBITS+DBITS  {commit_wr, rd, result}, for scoreboard clear
from_WB_to_AGEX  out  1+REGNOBITS+DBITS  same tuple, for forwarding
retired_count  out  DBITS  instructions retired
halted  out  1  core halted
canary_err  out  1  sticky canary mismatch
last_pc  out  DBITS  PC of most recent retired instruction

Behaviour:
- Reset (async): all registers 0, retired_count 0, last_pc 0, state RUN, halted 0, canary_err 0, drain counter 0.
- retire = valid && state==RUN && canary==CANARY_VAL.
- commit_wr = retire && wr_reg && rd!=0. At the posedge, regfile[rd] <= result. Register 0 always reads 0 and is never written.
- Read ports are combinational, with write-through. If commit_wr and rsX_idx==rd (nonzero), rsX_val = result, not the stale array value.
- from_WB_to_DE/AGEX are combinational from the current latch: {commit_wr, rd, result}. When commit_wr=0 the rd and result fields are don't-care.
- retired_count increments by 1 on each retire cycle, including the halt instruction. It wraps at 2^DBITS. last_pc <= pc on retire.
- Canary check: valid && state==RUN && canary!=CANARY_VAL sets canary_err (sticky until reset). That cycle does no commit and no count, and the FSM goes to HALTED next cycle.
- FSM:
  - RUN: retire && is_halt -> DRAIN with counter=0. The halt instruction does not write the regfile even if wr_reg=1.
  - DRAIN: counter increments each cycle. Latch inputs are ignored: no commits, no counts. At counter==DRAIN_CYCLES-1 -> HALTED.
  - HALTED: halted=1, all inputs ignored. Only reset exits.
- Simultaneous events:
  - Canary error takes priority over halt in the same cycle.
  - Reset mid-DRAIN or mid-HALTED returns to RUN with all state cleared.
- Latency: result is visible via the bypass in the commit cycle and in the array from the next cycle.

Decomposition:
- Shared package/define file holds the MEM latch field order and widths, CANARY_VAL, the FSM state encoding (RUN=2'd0, DRAIN=2'd1, HALTED=2'd2), and the WB-to-DE/AGEX bus widths.
- One sub-module, wb_regfile: 2^REGNOBITS x DBITS array, async reset, one write port, two write-through read ports, register 0 hardwired to zero.

Test Plan:
- Commit: latch {valid=1, rd=5, result=32'hDEAD_BEEF, wr_reg=1, canary=F}, rs1_idx=5 -> rs1_val=DEADBEEF the same cycle; retired_count=1 next cycle; read persists after valid drops.
- Register 0: rd=0, wr_reg=1, result=32'h1234 -> rs1_idx=0 reads 0; commit_wr=0; retired_count still increments.
- Halt: valid halt with wr_reg=1, rd=3 at pc=0x40 -> reg3 unchanged; last_pc=0x40; halted rises exactly DRAIN_CYCLES cycles after the DRAIN entry edge (3); valid latches during DRAIN/HALTED do not change count or regs.
- Canary: canary=4'h0 with valid=1, is_halt=1 -> canary_err=1, no retire, halted=1 next cycle.
- Async reset: assert reset mid-DRAIN between clock edges -> outputs 0 immediately; after release, a normal commit works.
- Wrap: preload retired_count to 32'hFFFF_FFFF, retire one -> 0.
